// File: rtl/scmp_bus_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scmp_bus_ctl : SC/MP bus-cycle sequencer and BREQ/ENIN/ENOUT arbiter.     |
// | Optional macro SCMP_BUS_ARB_EN enables the ARB state and daisy chain.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module scmp_bus_ctl #(
    parameter int ADS_CYC  = 1,
    parameter int DATA_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cyc_req,
    input  logic cyc_wr,
    output logic stall,
    output logic cyc_done,
    output logic rd_strobe,
    input  logic nhold,
    input  logic breq_i,
    input  logic enin,
    output logic breq_o,
    output logic enout,
    output logic ADS_n,
    output logic RD_n,
    output logic WR_n
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] ADS_LOAD  = 3'(ADS_CYC - 1);
    localparam logic [2:0] DATA_LOAD = 3'(DATA_CYC - 1);

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       wr_q, wr_nx;
    logic       grant;
    logic       own_nx;

`ifdef SCMP_BUS_ARB_EN
    logic breq_r;
    assign grant  = enin & ~breq_i;
    assign breq_o = breq_r;
`else
    logic unused_breq;
    assign unused_breq = breq_i;
    assign grant       = 1'b1;
    assign breq_o      = 1'b0;
`endif

    assign stall  = cyc_req & ~cyc_done;
    assign own_nx = (state_nx == ADDR) || (state_nx == DATA) || (state_nx == DONE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_nx    = wr_q;
        case (state)
            IDLE: begin
                if (cyc_req) begin
                    wr_nx = cyc_wr;
`ifdef SCMP_BUS_ARB_EN
                    state_nx = ARB;
`else
                    state_nx = ADDR;
                    cnt_nx   = ADS_LOAD;
`endif
                end
            end
            ARB: begin
                if (grant) begin
                    state_nx = ADDR;
                    cnt_nx   = ADS_LOAD;
                end
            end
            ADDR: begin
                if (cnt == 3'd0) begin
                    state_nx = DATA;
                    cnt_nx   = DATA_LOAD;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            DATA: begin
                // nhold only matters once the minimum strobe width has elapsed
                if (cnt != 3'd0) begin
                    cnt_nx = cnt - 3'd1;
                end else if (nhold) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pins are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            wr_q      <= 1'b0;
            ADS_n     <= 1'b1;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            cyc_done  <= 1'b0;
            rd_strobe <= 1'b0;
            enout     <= 1'b0;
`ifdef SCMP_BUS_ARB_EN
            breq_r    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            wr_q      <= wr_nx;
            ADS_n     <= (state_nx != ADDR);
            RD_n      <= !((state_nx == DATA) && !wr_nx);
            WR_n      <= !((state_nx == DATA) && wr_nx);
            cyc_done  <= (state_nx == DONE);
            rd_strobe <= (state_nx == DONE) && !wr_nx;
`ifdef SCMP_BUS_ARB_EN
            breq_r    <= own_nx;
            enout     <= own_nx ? 1'b0 : enin;
`else
            enout     <= enin;
`endif
        end
    end

endmodule
`default_nettype wire
